// File: rtl/and_share_arbiter_pkg.sv
// Shared defaults and width helpers for the round-robin AND-sharing arbiter.
package and_share_arbiter_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int WIDTH_DEFAULT = 8;

  // Requester index width; a single-bit index is kept even for degenerate counts.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/and_share_arbiter_if.sv
// Request/grant and result handshake bundle between requesters, arbiter and consumer.
interface and_share_arbiter_if
  import and_share_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
);
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH-1:0]       res_data;
  logic [ID_W-1:0]        res_id;

  modport master (
    output req, a_in, b_in, res_ready,
    input  gnt, res_valid, res_data, res_id
  );

  modport slave (
    input  req, a_in, b_in, res_ready,
    output gnt, res_valid, res_data, res_id
  );
endinterface

// File: rtl/and_share_arbiter_and_stage.sv
// Registered bitwise AND of the granted operands, tagged with the requester index.
module and_stage
  import and_share_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ID_W  = id_w(N_REQ_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [ID_W-1:0]  id_in,
  output logic [WIDTH-1:0] res_data,
  output logic [ID_W-1:0]  res_id
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]  id_q, id_d;

  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    if (load) begin
      data_d = a & b;
      id_d   = id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      id_q   <= '0;
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
    end
  end

  assign res_data = data_q;
  assign res_id   = id_q;
endmodule

// File: rtl/and_share_arbiter.sv
// Round-robin arbiter feeding one shared registered AND stage, with a valid/ready result port.
module and_share_arbiter
  import and_share_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  and_share_arbiter_if.slave bus
);
  localparam int ID_W = id_w(N_REQ);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;
  logic             accept;
  logic             transfer;
  logic [ID_W-1:0]  hi_idx, lo_idx, sel;
  logic             hi_found, lo_found;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] res_data;
  logic [ID_W-1:0]  res_id;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_idx   = ID_W'(i);
        lo_found = 1'b1;
        if (ID_W'(i) >= ptr_q) begin
          hi_idx   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? hi_idx : lo_idx;
  end

  assign accept   = !res_valid_q || bus.res_ready;
  assign transfer = !rst && accept && lo_found;

  always_comb begin
    gnt = '0;
    if (transfer) gnt[sel] = 1'b1;
  end

  assign a_sel = bus.a_in[sel*WIDTH +: WIDTH];
  assign b_sel = bus.b_in[sel*WIDTH +: WIDTH];

  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    if (transfer) begin
      ptr_d       = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
      res_valid_d = 1'b1;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
    end
  end

  and_stage #(
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) u_and_stage (
    .clk      (clk),
    .rst      (rst),
    .load     (transfer),
    .a        (a_sel),
    .b        (b_sel),
    .id_in    (sel),
    .res_data (res_data),
    .res_id   (res_id)
  );

  assign bus.gnt       = gnt;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data;
  assign bus.res_id    = res_id;
endmodule

// File: tb/tb_and_share_arbiter.sv
// Scoreboard bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_and_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    int           id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  and_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t mon_e;
  int   m_ptr = 0;
  logic m_valid = 1'b0;
  int   last_g = -1;
  logic [N-1:0] seen_gnt;
  logic [W-1:0] hold_data;
  int   hold_id;

  task automatic check(input string name, input int act, input int req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req_v, $time);
    end
  endtask

  task automatic set_op(input int i);
    bus.a_in[i*W +: W] = W'($urandom);
    bus.b_in[i*W +: W] = W'($urandom);
  endtask

  // One clock: inputs already driven; check grant, update model, advance to edge+1.
  task automatic cycle();
    int g;
    int idx;
    #3;
    g = -1;
    if (!rst && (!m_valid || bus.res_ready)) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && bus.req[idx]) g = idx;
      end
    end
    seen_gnt = bus.gnt;
    check("gnt", int'(bus.gnt), (g >= 0) ? (1 << g) : 0);
    check("res_valid", int'(bus.res_valid), int'(m_valid));
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      q.delete();
    end else if (g >= 0) begin
      q.push_back('{data: bus.a_in[g*W +: W] & bus.b_in[g*W +: W], id: g});
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=0x%0h/%0d required=none", bus.res_data, bus.res_id);
      end else begin
        mon_e = q.pop_front();
        check("res_data", int'(bus.res_data), int'(mon_e.data));
        check("res_id", int'(bus.res_id), mon_e.id);
      end
    end
  end

  initial begin
    bus.req       = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Idle after reset
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_res_data", int'(bus.res_data), 0);
      check("idle_res_valid", int'(bus.res_valid), 0);
    end

    // Single request from requester 2
    bus.req = 4'b0100;
    bus.a_in[2*W +: W] = 8'hF0;
    bus.b_in[2*W +: W] = 8'h3C;
    cycle();
    check("single_gnt", int'(seen_gnt), 4'b0100);
    bus.req = 4'b0000;
    check("single_valid", int'(bus.res_valid), 1);
    check("single_data", int'(bus.res_data), 8'h30);
    check("single_id", int'(bus.res_id), 2);
    cycle();

    // Fairness from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i);
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("fair_gnt", int'(seen_gnt), 1 << (i % N));
      check("fair_res_id", int'(bus.res_id), i % N);
      set_op(i % N);
    end

    // Backpressure with a held result
    bus.res_ready = 1'b0;
    hold_data = bus.res_data;
    hold_id   = int'(bus.res_id);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_gnt", int'(seen_gnt), 0);
      check("stall_data", int'(bus.res_data), int'(hold_data));
      check("stall_id", int'(bus.res_id), hold_id);
    end
    bus.res_ready = 1'b1;
    cycle();
    check("release_gnt", int'(seen_gnt), 4'b0001);
    check("release_valid", int'(bus.res_valid), 1);

    // Wrap and skip
    bus.req = 4'b1000;
    cycle();
    check("wrap_gnt3", int'(seen_gnt), 4'b1000);
    bus.req = 4'b0110;
    set_op(1);
    set_op(2);
    cycle();
    check("skip_gnt1", int'(seen_gnt), 4'b0010);
    bus.req = 4'b0001;
    set_op(0);
    cycle();
    check("wrap_gnt0", int'(seen_gnt), 4'b0001);

    // Reset while a result is stalled
    bus.req = 4'b0000;
    bus.res_ready = 1'b0;
    check("pre_rst_valid", int'(bus.res_valid), 1);
    bus.req = 4'b1010;
    set_op(1);
    set_op(3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("post_rst_valid", int'(bus.res_valid), 0);
    bus.res_ready = 1'b1;
    cycle();
    check("post_rst_gnt", int'(seen_gnt), 4'b0010);

    // Randomized traffic honouring hold-until-granted
    for (int c = 0; c < 400; c++) begin
      bus.res_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 79) == 0);
      cycle();
      if (last_g >= 0) bus.req[last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 1) == 1) begin
          bus.req[i] = 1'b1;
          set_op(i);
        end
      end
    end
    rst = 1'b0;

    // Drain
    bus.req = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
